fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Sequencing controller for the instruction-fetch stage. It owns the program counter, issues single-outstanding requests to the instruction memory bank over a req/ack handshake, and presents one fetched instruction at a time to the IF/ID boundary. It applies decode-stage stalls and branch redirects, and discards any in-flight fetch a redirect makes stale. It replaces free-running PC+4 stepping so that multi-cycle memory and pipeline stalls are handled correctly.

## Interface
- RESET_PC, 32, PC value loaded on reset (first fetch address)
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  IF/ID cannot accept this cycle
- branch_taken  in  1  single-cycle redirect request
- branch_target  in  32  redirect address, valid with branch_taken
- imem_req  out  1  fetch request, one-cycle pulse
- imem_addr  out  32  fetch address, valid while imem_req=1
- imem_ack  in  1  one-cycle pulse: imem_rdata valid
- imem_rdata  in  32  fetched instruction word
- if_valid  out  1  if_instr/if_pc_plus4 hold a live instruction
- if_instr  out  32  instruction for IF/ID
- if_pc_plus4  out  32  address of if_instr plus 4
- fetch_fault  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- Registers: pc, state, if_valid, if_instr, if_pc_plus4, fetch_fault.
- States: ISSUE, WAIT, DRAIN, FAULT.
- ISSUE:
  - Assert imem_req, imem_addr=pc, only if the output slot is free (`!if_valid || !stall`), then go to WAIT.
  - Otherwise remain in ISSUE with imem_req=0.
- WAIT, on imem_ack:
  - Load if_instr=imem_rdata, if_pc_plus4=pc+4, if_valid=1; pc=pc+4; go to ISSUE.
- Consumption: an instruction is taken at any edge where `if_valid && !stall`. At that edge if_valid clears unless a new ack loads the slot in the same cycle.
- branch_taken (any state except FAULT; priority over stall and ack):
  - pc=branch_target; if_valid=0.
  - ISSUE with imem_req=1 this cycle, or WAIT with no ack this cycle: go to DRAIN.
  - WAIT with ack this cycle: drop the data, go to ISSUE.
  - ISSUE with no request this cycle: stay in ISSUE.
- DRAIN:
  - imem_req=0. On imem_ack, discard imem_rdata (no output update), go to ISSUE.
  - A second branch_taken in DRAIN overwrites pc and stays in DRAIN.
- Arithmetic: pc+4 is 32-bit modulo; 0xFFFFFFFC wraps to 0x00000000 with no flag.
- Requests outstanding: never more than 1. imem_ack outside WAIT/DRAIN is ignored.

## Timing
- Reset (reset_n=0 at edge): pc=RESET_PC, state=ISSUE, if_valid=0, if_instr=0, if_pc_plus4=0, fetch_fault=0.
  - imem_req is 0 while reset_n=0 and is asserted in the first cycle after release.
- Reset mid-operation discards any outstanding fetch. An ack arriving after reset in ISSUE is ignored.
- imem_req and imem_addr are combinational from state/pc/if_valid/stall. All other outputs are registered.
- Memory ack arrives at the earliest 1 cycle after imem_req. Fetch latency is req cycle N, ack cycle N+k (k≥1), if_valid at N+k+1.
- Maximum throughput is one instruction per 2 cycles with a 1-cycle memory.
- A branch in cycle N sets imem_addr=branch_target no earlier than cycle N+1.

## Configuration
- IF_MISALIGN_TRAP_EN defined:
  - branch_taken with branch_target[1:0]≠0 sets fetch_fault=1, if_valid=0, state=FAULT.
  - FAULT issues no requests and ignores everything except reset_n.
- Undefined:
  - branch_target[1:0] is forced to 00 when loaded into pc.
  - fetch_fault is tied to 0; FAULT is unreachable.

## Test plan
- Reset release, 1-cycle memory returning 0x11111111: imem_addr=0x20 in the first cycle; if_valid=1, if_instr=0x11111111, if_pc_plus4=0x24 two cycles later. The next req has addr=0x24.
- stall=1 for 5 cycles while if_valid=1: if_instr is stable, no imem_req; the next req comes the cycle stall drops, addr=previous+4.
- 3-cycle memory, branch_taken to 0x100 in the cycle after req: the stale ack data is discarded, if_valid stays 0, the next req has addr=0x100.
- branch_taken and imem_ack in the same WAIT cycle, target 0x200: output not updated; req addr=0x200 in the next cycle.
- pc=0xFFFFFFFC fetched: if_pc_plus4=0x00000000, next req addr=0x0.
- Branch to 0x102: with IF_MISALIGN_TRAP_EN, fetch_fault=1 and no further req. Without it, the next req addr=0x100 and fetch_fault=0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port: single-outstanding req/ack handshake.
// The sequencer is the master; the memory bank is the slave.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one fetch at a time, holds a one-entry IF/ID slot.
// Define IF_MISALIGN_TRAP_EN to trap misaligned branch targets; otherwise their low bits are cleared.
//
//   state    | meaning
//   ST_ISSUE | no fetch outstanding; request pc when the output slot is free
//   ST_WAIT  | fetch outstanding, its data is wanted
//   ST_DRAIN | fetch outstanding but made stale by a redirect; data is discarded
//   ST_FAULT | misaligned redirect trapped; frozen until reset
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  fetch_sequencer_if.master imem,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc_plus4,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_DRAIN, ST_FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic        issue;
  logic [31:0] pc_inc;
  logic [31:0] br_pc;
  logic        br_misaligned;

  assign issue  = reset_n && (state_q == ST_ISSUE) && (!valid_q || !stall);
  assign pc_inc = pc_q + 32'd4;

`ifdef IF_MISALIGN_TRAP_EN
  assign br_pc         = branch_target;
  assign br_misaligned = |branch_target[1:0];
`else
  assign br_pc         = branch_target & 32'hFFFF_FFFC;
  assign br_misaligned = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_ISSUE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    fault_d = fault_q;

    if (valid_q && !stall) valid_d = 1'b0;

    case (state_q)
      ST_ISSUE: if (issue) state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem.imem_ack) begin
          state_d = ST_ISSUE;
          pc_d    = pc_inc;
          valid_d = 1'b1;
          instr_d = imem.imem_rdata;
          pc4_d   = pc_inc;
        end
      end
      ST_DRAIN: if (imem.imem_ack) state_d = ST_ISSUE;
      default: ;
    endcase

    // A redirect wins over stall and ack; any fetch still in flight after this edge goes stale.
    if (branch_taken && state_q != ST_FAULT) begin
      valid_d = 1'b0;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      pc_d    = br_pc;
      case (state_q)
        ST_ISSUE: state_d = issue ? ST_DRAIN : ST_ISSUE;
        ST_WAIT:  state_d = imem.imem_ack ? ST_ISSUE : ST_DRAIN;
        default:  state_d = imem.imem_ack ? ST_ISSUE : ST_DRAIN;
      endcase
      if (br_misaligned) begin
        state_d = ST_FAULT;
        fault_d = 1'b1;
      end
    end
  end

  always_comb begin
    imem.imem_req  = issue;
    imem.imem_addr = pc_q;
  end

  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc_plus4 = pc4_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, corner sequences, random run
// against a transaction-level model (pc, one outstanding fetch with a stale flag, one output slot).
module tb_fetch_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_0020;

  logic        clock = 1'b0;
  logic        reset_n, stall, branch_taken;
  logic [31:0] branch_target;
  logic        if_valid, fetch_fault;
  logic [31:0] if_instr, if_pc_plus4;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(bus),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
    .fetch_fault(fetch_fault)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  // reference model
  logic [31:0] m_pc, m_instr, m_p4, m_infl_addr;
  bit          m_valid, m_fault, m_infl, m_stale;

  // values seen at the last sample point
  logic        obs_req, obs_valid, obs_fault;
  logic [31:0] obs_addr, obs_instr, obs_p4;

  // memory responder
  bit mem_busy = 0;
  int mem_cnt  = 0;

  typedef struct {
    logic rn, st, br; logic [31:0] tgt; logic ak; logic [31:0] rd;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_instr, e_p4;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = 0; m_p4 = 0; m_infl_addr = 0;
    m_valid = 0; m_fault = 0; m_infl = 0; m_stale = 0;
  endtask

  task automatic step(input logic rn, input logic st, input logic br, input logic [31:0] tgt,
                      input logic ak, input logic [31:0] rd);
    bit e_req, hit, trap;
    reset_n = rn; stall = st; branch_taken = br; branch_target = tgt;
    bus.imem_ack = ak; bus.imem_rdata = rd;
    @(negedge clock);
    e_req = rn && !m_fault && !m_infl && (!m_valid || !st);
    obs_req = bus.imem_req; obs_addr = bus.imem_addr; obs_valid = if_valid;
    obs_instr = if_instr; obs_p4 = if_pc_plus4; obs_fault = fetch_fault;
    if (chk_en) begin
      chk("model_req", obs_req, e_req);
      if (e_req) chk("model_addr", obs_addr, m_pc);
      chk("model_valid", obs_valid, m_valid);
      chk("model_instr", obs_instr, m_instr);
      chk("model_pc_plus4", obs_p4, m_p4);
      chk("model_fault", obs_fault, m_fault);
    end
`ifdef IF_MISALIGN_TRAP_EN
    trap = 1;
`else
    trap = 0;
`endif
    if (!rn) model_reset();
    else if (!m_fault) begin
      hit = ak && m_infl;
      if (m_valid && !st) m_valid = 0;
      if (hit) begin
        m_infl = 0;
        if (!m_stale && !br) begin
          m_valid = 1; m_instr = rd; m_p4 = m_infl_addr + 32'd4; m_pc = m_infl_addr + 32'd4;
        end
      end
      if (e_req) begin m_infl = 1; m_infl_addr = m_pc; m_stale = 0; end
      if (br) begin
        m_valid = 0;
        if (trap && tgt[1:0] != 2'b00) m_fault = 1;
        else m_pc = {tgt[31:2], 2'b00};
        if (m_infl) m_stale = 1;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic mem_step(input logic rn, input logic st, input logic br, input logic [31:0] tgt,
                          input int lat);
    logic ak = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin ak = 1'b1; mem_busy = 0; end
    end
    step(rn, st, br, tgt, ak, $urandom);
    if (!rn) mem_busy = 0;
    else if (obs_req === 1'b1) begin mem_busy = 1; mem_cnt = lat; end
  endtask

  task automatic do_reset();
    mem_step(0, 0, 0, 0, 1);
    mem_step(0, 0, 0, 0, 1);
  endtask

  task automatic wait_req(input int lat, output bit found);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      mem_step(1, 0, 0, 0, lat);
      if (obs_req === 1'b1) found = 1;
    end
  endtask

  initial begin
    bit found;
    int nreq;
    logic [31:0] tgt;

    tbl[0]  = '{0,0,0,32'h0,  0,32'h0,        0,32'h0,  0,32'h0,        32'h0};
    tbl[1]  = '{1,0,0,32'h0,  0,32'h0,        1,32'h20, 0,32'h0,        32'h0};
    tbl[2]  = '{1,0,0,32'h0,  1,32'h11111111, 0,32'h0,  0,32'h0,        32'h0};
    for (int i = 3; i <= 7; i++)
      tbl[i] = '{1,1,0,32'h0, 0,32'h0,        0,32'h0,  1,32'h11111111, 32'h24};
    tbl[8]  = '{1,0,0,32'h0,  0,32'h0,        1,32'h24, 1,32'h11111111, 32'h24};
    tbl[9]  = '{1,0,0,32'h0,  1,32'h22222222, 0,32'h0,  0,32'h11111111, 32'h24};
    tbl[10] = '{1,0,0,32'h0,  0,32'h0,        1,32'h28, 1,32'h22222222, 32'h28};
    tbl[11] = '{1,0,1,32'h200,1,32'h33333333, 0,32'h0,  0,32'h22222222, 32'h28};
    tbl[12] = '{1,0,0,32'h0,  0,32'h0,        1,32'h200,0,32'h22222222, 32'h28};
    tbl[13] = '{1,0,0,32'h0,  1,32'h44444444, 0,32'h0,  0,32'h22222222, 32'h28};
    tbl[14] = '{1,1,0,32'h0,  0,32'h0,        0,32'h0,  1,32'h44444444, 32'h204};
    tbl[15] = '{1,0,1,32'h300,0,32'h0,        1,32'h204,1,32'h44444444, 32'h204};
    tbl[16] = '{1,0,0,32'h0,  1,32'h55555555, 0,32'h0,  0,32'h44444444, 32'h204};
    tbl[17] = '{1,0,0,32'h0,  0,32'h0,        1,32'h300,0,32'h44444444, 32'h204};
    tbl[18] = '{1,0,0,32'h0,  0,32'h0,        0,32'h0,  0,32'h44444444, 32'h204};

    step(0, 0, 0, 0, 0, 0);
    chk_en = 1;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rn, tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].ak, tbl[i].rd);
      chk($sformatf("vec%0d_req", i), obs_req, tbl[i].e_req);
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), obs_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), obs_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d_instr", i), obs_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d_pc_plus4", i), obs_p4, tbl[i].e_p4);
    end

    // 3-cycle memory, redirect in the cycle after the request
    do_reset();
    mem_step(1, 0, 0, 0, 3);
    chk("drain_first_req", obs_req, 1);
    mem_step(1, 0, 1, 32'h100, 3);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      mem_step(1, 0, 0, 0, 3);
      if (obs_req === 1'b1) begin
        found = 1;
        chk("drain_redirect_addr", obs_addr, 32'h100);
        chk("drain_latency", i, 2);
      end else chk("drain_valid_low", obs_valid, 0);
    end
    chk("drain_req_seen", found, 1);

    // PC wrap at the top of the address space
    do_reset();
    mem_step(1, 0, 1, 32'hFFFF_FFFC, 1);
    wait_req(1, found);
    chk("wrap_req_seen", found, 1);
    chk("wrap_addr", obs_addr, 32'hFFFF_FFFC);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      mem_step(1, 0, 0, 0, 1);
      if (obs_valid === 1'b1) begin
        found = 1;
        chk("wrap_pc_plus4", obs_p4, 32'h0);
        chk("wrap_next_req", obs_req, 1);
        chk("wrap_next_addr", obs_addr, 32'h0);
      end
    end
    chk("wrap_valid_seen", found, 1);

    // an ack in ISSUE right after reset is ignored
    do_reset();
    step(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    step(1, 0, 0, 0, 0, 0);
    chk("spurious_valid", obs_valid, 0);
    step(1, 0, 0, 0, 1, 32'h600D_600D);
    step(1, 1, 0, 0, 0, 0);
    chk("spurious_after_valid", obs_valid, 1);
    chk("spurious_after_instr", obs_instr, 32'h600D_600D);
    chk("spurious_after_pc_plus4", obs_p4, RST_PC + 32'd4);

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tgt = $urandom;
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifdef IF_MISALIGN_TRAP_EN
      tgt[1:0] = 2'b00;
`endif
      mem_step(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 30),
               ($urandom_range(0, 99) < 8), tgt, $urandom_range(1, 3));
    end

    // misaligned redirect
    do_reset();
    mem_step(1, 0, 1, 32'h102, 1);
`ifdef IF_MISALIGN_TRAP_EN
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      mem_step(1, 0, 0, 0, 1);
      if (obs_req !== 1'b0) nreq++;
    end
    chk("misalign_fault", obs_fault, 1);
    chk("misalign_no_req", nreq, 0);
    chk("misalign_valid", obs_valid, 0);
`else
    nreq = 0;
    wait_req(1, found);
    chk("misalign_req_seen", found, 1);
    chk("misalign_addr", obs_addr, 32'h100);
    chk("misalign_no_fault", obs_fault, nreq);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
